// File: rtl/alu_acc_ctrl.sv
// Accumulator controller around a 4-bit combinational ALU.
// Command in, one execute cycle, response out with flags.
module alu_acc_ctrl #(
    parameter int OVF_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [3:0]           cmd_b,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [2:0]           alu_mod,
    input  logic [3:0]           alu_result,
    input  logic                 alu_zero,
    input  logic                 alu_c,
    input  logic                 alu_ov,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [3:0]           rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_c,
    output logic                 rsp_ov,
    output logic                 rsp_err,
    output logic [3:0]           acc,
    output logic [OVF_CNT_W-1:0] ovf_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [2:0] OP_LOAD = 3'b100;
    localparam logic [2:0] OP_CLR  = 3'b101;
    localparam logic [2:0] MOD_OFF = 3'b111;

    localparam logic [OVF_CNT_W-1:0] CNT_ONE =
        {{(OVF_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [OVF_CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] op_q;
    logic [3:0] b_q;

    logic       upd;
    logic [3:0] acc_nxt;
    logic       z_nxt;
    logic       c_nxt;
    logic       ov_nxt;
    logic       err_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command capture on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
            b_q  <= '0;
        end else if (cmd_valid && cmd_ready) begin
            op_q <= cmd_op;
            b_q  <= cmd_b;
        end
    end

    // Next state, handshakes, ALU drive and execute results
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = acc;
        alu_b     = '0;
        alu_mod   = MOD_OFF;
        upd       = 1'b0;
        acc_nxt   = acc;
        z_nxt     = 1'b0;
        c_nxt     = 1'b0;
        ov_nxt    = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
                upd       = 1'b1;
                unique case (1'b1)
                    !op_q[2]: begin
                        alu_b   = b_q;
                        alu_mod = op_q;
                        acc_nxt = alu_result;
                        z_nxt   = alu_zero;
                        c_nxt   = alu_c;
                        ov_nxt  = alu_ov;
                    end
                    (op_q == OP_LOAD): begin
                        acc_nxt = b_q;
                        z_nxt   = (b_q == 4'd0);
                    end
                    (op_q == OP_CLR): begin
                        acc_nxt = '0;
                        z_nxt   = 1'b1;
                    end
                    default: begin
                        err_nxt = 1'b1;
                    end
                endcase
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Accumulator and response registers, written leaving EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_c      <= 1'b0;
            rsp_ov     <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (upd) begin
            acc        <= acc_nxt;
            rsp_result <= acc_nxt;
            rsp_zero   <= z_nxt;
            rsp_c      <= c_nxt;
            rsp_ov     <= ov_nxt;
            rsp_err    <= err_nxt;
        end
    end

    // Saturating count of overflowing commands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (upd && ov_nxt && (ovf_cnt != CNT_MAX)) begin
            ovf_cnt <= ovf_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Bench for alu_acc_ctrl: stub ALU, command-level model,
// per-cycle monitor and literal checks from hand calculations.
module tb_alu_acc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [3:0] cmd_b = '0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_mod;
    logic [3:0] alu_result;
    logic       alu_zero;
    logic       alu_c;
    logic       alu_ov;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [3:0] rsp_result;
    logic       rsp_zero;
    logic       rsp_c;
    logic       rsp_ov;
    logic       rsp_err;
    logic [3:0] acc;
    logic [3:0] ovf_cnt;

    int n_chk = 0;
    int n_fail = 0;

    logic [3:0] m_acc = '0;
    logic [3:0] m_ovf = '0;
    logic [3:0] e_res = '0;
    logic       e_z = 1'b0;
    logic       e_c = 1'b0;
    logic       e_ov = 1'b0;
    logic       e_err = 1'b0;

    alu_acc_ctrl #(.OVF_CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_b      (cmd_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_mod    (alu_mod),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_c      (alu_c),
        .alu_ov     (alu_ov),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_c      (rsp_c),
        .rsp_ov     (rsp_ov),
        .rsp_err    (rsp_err),
        .acc        (acc),
        .ovf_cnt    (ovf_cnt)
    );

    always #5 clk = ~clk;

    // Stub ALU: returns {zero, carry, overflow, result}.
    // Unused modes return all-ones so misuse is visible.
    function automatic logic [6:0] alu_f(input logic [3:0] a,
                                         input logic [3:0] b,
                                         input logic [2:0] m);
        logic [4:0] s;
        logic [3:0] r;
        logic       z;
        logic       c;
        logic       v;
        r = 4'hf;
        z = 1'b1;
        c = 1'b1;
        v = 1'b1;
        s = '0;
        case (m)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[3:0];
                c = s[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
                z = (r == 4'd0);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 5'd1;
                r = s[3:0];
                c = s[4];
                v = (a[3] != b[3]) && (r[3] != a[3]);
                z = (r == 4'd0);
            end
            3'd2: begin
                r = {1'b1, ~a[2:0]};
                z = 1'b0;
                c = 1'b0;
                v = 1'b0;
            end
            3'd3: begin
                r = a & b;
                z = 1'b0;
                c = 1'b0;
                v = 1'b0;
            end
            default: ;
        endcase
        return {z, c, v, r};
    endfunction

    always_comb begin
        {alu_zero, alu_c, alu_ov, alu_result} =
            alu_f(alu_a, alu_b, alu_mod);
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    // Command-level model of what one command must produce
    task automatic model_cmd(input logic [2:0] op,
                             input logic [3:0] b);
        logic [6:0] f;
        e_z = 1'b0;
        e_c = 1'b0;
        e_ov = 1'b0;
        e_err = 1'b0;
        if (op <= 3'd3) begin
            f = alu_f(m_acc, b, op);
            e_res = f[3:0];
            e_ov = f[4];
            e_c = f[5];
            e_z = f[6];
        end else if (op == 3'd4) begin
            e_res = b;
            e_z = (b == 4'd0);
        end else if (op == 3'd5) begin
            e_res = 4'd0;
            e_z = 1'b1;
        end else begin
            e_res = m_acc;
            e_err = 1'b1;
        end
        m_acc = e_res;
        if (e_ov && m_ovf != 4'hf) m_ovf = m_ovf + 4'd1;
    endtask

    // Present a command, wait for accept, check EXEC timing
    task automatic issue(input logic [2:0] op,
                         input logic [3:0] b,
                         input int hold);
        bit ok;
        logic [3:0] old_acc;
        ok = 1'b0;
        rsp_ready = (hold == 0);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_b = b;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            if (ok) break;
        end
        #1;
        cmd_valid = 1'b0;
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        old_acc = m_acc;
        model_cmd(op, b);
        @(negedge clk);
        chk("exec_rsp_valid", rsp_valid, 0);
        chk("exec_cmd_ready", cmd_ready, 0);
        chk("exec_alu_a", alu_a, old_acc);
        chk("exec_alu_b", alu_b, (op <= 3'd3) ? b : 4'd0);
        chk("exec_alu_mod", alu_mod, (op <= 3'd3) ? op : 3'd7);
        chk("exec_acc", acc, old_acc);
        @(negedge clk);
        chk("resp_latency", rsp_valid, 1);
    endtask

    // Hold off the response, optionally presenting the next command
    task automatic finish(input int hold,
                          input bit pre,
                          input logic [2:0] nop,
                          input logic [3:0] nb);
        for (int i = 0; i < hold; i++) begin
            if (pre) begin
                cmd_valid = 1'b1;
                cmd_op = nop;
                cmd_b = nb;
            end
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [2:0] op, input logic [3:0] b);
        issue(op, b, 0);
        finish(0, 1'b0, 3'd0, 4'd0);
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                chk("rsp_result", rsp_result, e_res);
                chk("rsp_zero", rsp_zero, e_z);
                chk("rsp_c", rsp_c, e_c);
                chk("rsp_ov", rsp_ov, e_ov);
                chk("rsp_err", rsp_err, e_err);
                chk("resp_acc", acc, m_acc);
                chk("resp_ovf_cnt", ovf_cnt, m_ovf);
                chk("resp_cmd_ready", cmd_ready, 0);
            end
            if (cmd_ready) begin
                chk("idle_acc", acc, m_acc);
                chk("idle_ovf_cnt", ovf_cnt, m_ovf);
                chk("idle_alu_a", alu_a, m_acc);
                chk("idle_alu_b", alu_b, 0);
                chk("idle_alu_mod", alu_mod, 7);
                chk("idle_rsp_valid", rsp_valid, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_acc", acc, 0);
        chk("rst_ovf_cnt", ovf_cnt, 0);
        chk("rst_alu_mod", alu_mod, 7);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_err", rsp_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_cmd_ready", cmd_ready, 1);

        run(3'd4, 4'd7);
        run(3'd0, 4'd1);
        chk("t1_result", rsp_result, 8);
        chk("t1_ov", rsp_ov, 1);
        chk("t1_c", rsp_c, 0);
        chk("t1_zero", rsp_zero, 0);
        chk("t1_ovf_cnt", ovf_cnt, 1);
        chk("t1_acc", acc, 8);

        run(3'd4, 4'd3);
        run(3'd1, 4'd3);
        chk("t2_result", rsp_result, 0);
        chk("t2_zero", rsp_zero, 1);
        chk("t2_c", rsp_c, 1);
        chk("t2_ov", rsp_ov, 0);
        run(3'd4, 4'd15);
        run(3'd0, 4'd1);
        chk("t2b_result", rsp_result, 0);
        chk("t2b_c", rsp_c, 1);
        chk("t2b_ov", rsp_ov, 0);

        run(3'd4, 4'b1010);
        run(3'd2, 4'd0);
        chk("t3_neg", rsp_result, 4'b1101);
        run(3'd3, 4'b0110);
        chk("t3_and", rsp_result, 4'b0100);
        chk("t3_and_flags", {rsp_zero, rsp_c, rsp_ov}, 0);

        run(3'd5, 4'd9);
        chk("clr_acc", acc, 0);
        chk("clr_zero", rsp_zero, 1);
        run(3'd4, 4'd0);
        chk("load0_zero", rsp_zero, 1);

        issue(3'd4, 4'd2, 5);
        finish(5, 1'b1, 3'd0, 4'd3);
        chk("bp_not_taken", acc, 2);
        run(3'd0, 4'd3);
        chk("bp_next_acc", acc, 5);

        run(3'd6, 4'd9);
        chk("ill_err", rsp_err, 1);
        chk("ill_result", rsp_result, 5);
        chk("ill_flags", {rsp_zero, rsp_c, rsp_ov}, 0);
        chk("ill_acc", acc, 5);
        run(3'd7, 4'd1);
        chk("ill7_err", rsp_err, 1);

        for (int i = 0; i < 16; i++) begin
            run(3'd4, 4'd7);
            run(3'd0, 4'd1);
        end
        chk("sat_ovf_cnt", ovf_cnt, 15);

        issue(3'd4, 4'd4, 1);
        #2;
        rst_n = 1'b0;
        m_acc = '0;
        m_ovf = '0;
        #1;
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_acc", acc, 0);
        chk("arst_ovf_cnt", ovf_cnt, 0);
        chk("arst_rsp_result", rsp_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_idle", cmd_ready, 1);
        chk("arst_no_rsp", rsp_valid, 0);
        run(3'd0, 4'd2);
        chk("post_rst_acc", acc, 2);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
